// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester write arbiter in front of a register-file write port.
// After reset, or on clear_i, it walks every register address and writes zero (busy_o high).
// After that it grants one requester per cycle, alternating when both are valid.
// A grant is registered onto the write port one cycle later.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   clear_i           restart the zeroing sweep (honoured only while arbitrating)
//   reqN_valid_i      requester N has a write pending
//   reqN_addr_i       requester N destination register
//   reqN_data_i       requester N write data
//   reqN_ready_o      requester N accepted this cycle (combinational on valid)
//   Reg_Write_o       registered register-file write enable
//   Write_Register_o  registered register-file write address
//   Write_Data_o      registered register-file write data
//   busy_o            zeroing sweep in progress
module rf_write_arbiter #(
  parameter int unsigned WD  = 32,
  parameter int unsigned SEL = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_i,
  input  logic           req0_valid_i,
  input  logic [SEL-1:0] req0_addr_i,
  input  logic [WD-1:0]  req0_data_i,
  output logic           req0_ready_o,
  input  logic           req1_valid_i,
  input  logic [SEL-1:0] req1_addr_i,
  input  logic [WD-1:0]  req1_data_i,
  output logic           req1_ready_o,
  output logic           Reg_Write_o,
  output logic [SEL-1:0] Write_Register_o,
  output logic [WD-1:0]  Write_Data_o,
  output logic           busy_o
);

  typedef enum logic [0:0] {StInit, StArb} state_e;

  localparam logic [SEL-1:0] IdxLast = {SEL{1'b1}};

  state_e         state_q, state_d;
  logic [SEL-1:0] idx_q, idx_d;
  // 1 means requester 1 was granted most recently, so requester 0 wins the next tie.
  logic           last_grant_q, last_grant_d;
  logic           reg_write_q, reg_write_d;
  logic [SEL-1:0] wr_addr_q, wr_addr_d;
  logic [WD-1:0]  wr_data_q, wr_data_d;

  logic arb_open;
  logic grant0, grant1;

  // Clear beats any grant; reset also masks grants since the handshake would be dropped.
  assign arb_open = (state_q == StArb) && !clear_i && !reset;
  assign grant0   = arb_open && req0_valid_i && (!req1_valid_i || last_grant_q);
  assign grant1   = arb_open && req1_valid_i && (!req0_valid_i || !last_grant_q);

  assign req0_ready_o     = grant0;
  assign req1_ready_o     = grant1;
  assign busy_o           = (state_q == StInit);
  assign Reg_Write_o      = reg_write_q;
  assign Write_Register_o = wr_addr_q;
  assign Write_Data_o     = wr_data_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      StInit: begin
        // clear_i is deliberately ignored here: the sweep neither restarts nor extends.
        reg_write_d = 1'b1;
        wr_addr_d   = idx_q;
        wr_data_d   = '0;
        idx_d       = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (clear_i) begin
          state_d = StInit;
          idx_d   = '0;
        end else if (grant0) begin
          last_grant_d = 1'b0;
          // Register 0 is hard-wired: accept the write but never issue it.
          if (req0_addr_i != '0) begin
            reg_write_d = 1'b1;
            wr_addr_d   = req0_addr_i;
            wr_data_d   = req0_data_i;
          end
        end else if (grant1) begin
          last_grant_d = 1'b1;
          if (req1_addr_i != '0) begin
            reg_write_d = 1'b1;
            wr_addr_d   = req1_addr_i;
            wr_data_d   = req1_data_i;
          end
        end
      end
      default: begin
        state_d = StInit;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      idx_q        <= '0;
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int NREG = 32;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        r0, r1;
  logic        rw;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        busy;

  rf_write_arbiter #(
    .WD (32),
    .SEL(5)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .clear_i         (clr),
    .req0_valid_i    (v0),
    .req0_addr_i     (a0),
    .req0_data_i     (d0),
    .req0_ready_o    (r0),
    .req1_valid_i    (v1),
    .req1_addr_i     (a1),
    .req1_data_i     (d1),
    .req1_ready_o    (r1),
    .Reg_Write_o     (rw),
    .Write_Register_o(wa),
    .Write_Data_o    (wd),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep countdown, a "who went last" marker and the port contents.
  bit          m_ok = 0;
  int          m_left;
  int          m_addr;
  int          m_last;
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic int exp_grant();
    if (rst || !m_ok || m_left > 0 || clr) return -1;
    if (v0 && v1) return (m_last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Inputs are set at the negedge; check at +2, then advance the model across the posedge.
  task automatic cyc();
    int g;
    logic [4:0]  ga;
    logic [31:0] gd;
    #2;
    if (m_ok) begin
      g = exp_grant();
      chk("busy", busy, m_left > 0);
      chk("ready0", r0, g == 0);
      chk("ready1", r1, g == 1);
      chk("we", rw, m_rw);
      chk("waddr", wa, m_wa);
      chk("wdata", wd, m_wd);
    end
    @(posedge clk);
    g = exp_grant();
    if (rst) begin
      m_ok = 1; m_left = NREG; m_addr = 0; m_last = 1;
      m_rw = 0; m_wa = '0; m_wd = '0;
    end else if (m_ok) begin
      if (m_left > 0) begin
        m_rw = 1; m_wa = 5'(m_addr); m_wd = '0;
        m_addr++; m_left--;
      end else if (clr) begin
        m_left = NREG; m_addr = 0; m_rw = 0;
      end else if (g >= 0) begin
        m_last = g;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        if (ga != 0) begin
          m_rw = 1; m_wa = ga; m_wd = gd;
        end else begin
          m_rw = 0;
        end
      end else begin
        m_rw = 0;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table starts on the first arbitration cycle after a sweep, with requester 0 favoured.
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    tbl[3] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    tbl[4] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd4, 32'h44};
    tbl[6] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
    tbl[7] = '{1'b1, 5'd9, 32'h9,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd9, 32'h9};
    tbl[8] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 1'b1, 5'd8, 32'h88};

    rst = 1; clr = 0;
    v0 = 0; a0 = '0; d0 = '0;
    v1 = 0; a1 = '0; d1 = '0;
    @(negedge clk);
    cyc();
    cyc();

    // Sweep after reset release with both requesters pushing.
    rst = 0;
    v0 = 1; a0 = 5'd3; d0 = 32'hAAAA;
    v1 = 1; a1 = 5'd4; d1 = 32'hBBBB;
    for (int i = 0; i < NREG; i++) begin
      if (i > 0) begin
        #1;
        chk("init_ready", {r0, r1}, 2'b00);
      end
      cyc();
      chk("init_we", rw, 1'b1);
      chk("init_addr", wa, i);
      chk("init_data", wd, 32'h0);
      chk("init_busy", busy, i < NREG - 1);
    end

    for (int k = 0; k < 9; k++) begin
      v0 = tbl[k].v0; a0 = tbl[k].a0; d0 = tbl[k].d0;
      v1 = tbl[k].v1; a1 = tbl[k].a1; d1 = tbl[k].d1;
      #1;
      chk("tbl_ready0", r0, tbl[k].r0);
      chk("tbl_ready1", r1, tbl[k].r1);
      cyc();
      chk("tbl_we", rw, tbl[k].rw);
      chk("tbl_addr", wa, tbl[k].wa);
      chk("tbl_data", wd, tbl[k].wd);
    end

    // Clear beats a grant; a second clear mid-sweep is ignored.
    v0 = 1; a0 = 5'd6; d0 = 32'h66;
    v1 = 0;
    clr = 1;
    #1;
    chk("clr_ready0", r0, 1'b0);
    cyc();
    chk("clr_we", rw, 1'b0);
    chk("clr_busy", busy, 1'b1);
    for (int i = 0; i < NREG; i++) begin
      clr = (i == 10);
      cyc();
      chk("clr_sweep_addr", wa, i);
      chk("clr_sweep_we", rw, 1'b1);
    end
    clr = 0;
    #1;
    chk("clr_sweep_done", busy, 1'b0);
    cyc();

    // Reset in the middle of a sweep restarts it from address 0.
    clr = 1;
    cyc();
    clr = 0;
    for (int i = 0; i < 7; i++) cyc();
    chk("mid_addr", wa, 6);
    rst = 1;
    cyc();
    chk("rst_we", rw, 1'b0);
    chk("rst_addr", wa, 0);
    chk("rst_busy", busy, 1'b1);
    rst = 0;
    for (int i = 0; i < NREG; i++) begin
      cyc();
      chk("rst_sweep_addr", wa, i);
    end
    #1;
    chk("rst_sweep_done", busy, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 59) == 0);
      v0  = $urandom_range(0, 2) != 0;
      v1  = $urandom_range(0, 2) != 0;
      a0  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      a1  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d0  = $urandom;
      d1  = $urandom;
      cyc();
    end
    rst = 0; clr = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
